// File: rtl/memwb_stage_pkg.sv
// Shared encodings and width defaults for the MEM/WB stage and its load extender.
package memwb_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        SZ_B  = 2'd0,
        SZ_H  = 2'd1,
        SZ_W  = 2'd2,
        SZ_W3 = 2'd3
    } mem_size_e;

endpackage

// File: rtl/memwb_stage_load_extend.sv
// Load lane extraction with sign/zero extension; halves use byte_off[1] only.
module load_extend
    import memwb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        size,
    input  logic              mem_unsigned,
    input  logic [1:0]        byte_off,
    output logic [DATA_W-1:0] ext_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        bsign_s;
    logic        hsign_s;

    // Select the addressed lane and widen it according to the load size.
    always_comb begin
        byte_s   = mem_data[{byte_off, 3'b000} +: 8];
        half_s   = mem_data[{byte_off[1], 4'b0000} +: 16];
        bsign_s  = ~mem_unsigned & byte_s[7];
        hsign_s  = ~mem_unsigned & half_s[15];
        ext_data = mem_data;
        case (size)
            SZ_B:    ext_data = {{(DATA_W-8){bsign_s}}, byte_s};
            SZ_H:    ext_data = {{(DATA_W-16){hsign_s}}, half_s};
            SZ_W:    ext_data = mem_data;
            default: ext_data = mem_data;
        endcase
    end

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline register and write-back mux feeding the register file.
// Optional macro WB_BYPASS_EN adds WB->EX forwarding compare outputs.
module memwb_stage
    import memwb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_unsigned,
    input  logic [1:0]        in_byte_off,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_pc_plus4,
    input  logic [ADDR_W-1:0] in_dest,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0] ex_rs_a,
    input  logic [ADDR_W-1:0] ex_rs_b,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              wb_reg_write,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retire_count
);

    logic              valid_r;
    logic              reg_write_r;
    logic [1:0]        wb_sel_r;
    logic [1:0]        mem_size_r;
    logic              mem_unsigned_r;
    logic [1:0]        byte_off_r;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] mem_r;
    logic [DATA_W-1:0] pc4_r;
    logic [ADDR_W-1:0] dest_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] load_s;
    logic [DATA_W-1:0] mux_s;

    assign in_ready = ~stall;

    // Pipeline register: flush only kills valid, stall holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r        <= 1'b0;
            reg_write_r    <= 1'b0;
            wb_sel_r       <= 2'd0;
            mem_size_r     <= 2'd0;
            mem_unsigned_r <= 1'b0;
            byte_off_r     <= 2'd0;
            alu_r          <= {DATA_W{1'b0}};
            mem_r          <= {DATA_W{1'b0}};
            pc4_r          <= {DATA_W{1'b0}};
            dest_r         <= {ADDR_W{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (!stall) begin
            valid_r        <= in_valid;
            reg_write_r    <= in_reg_write;
            wb_sel_r       <= in_wb_sel;
            mem_size_r     <= in_mem_size;
            mem_unsigned_r <= in_mem_unsigned;
            byte_off_r     <= in_byte_off;
            alu_r          <= in_alu_result;
            mem_r          <= in_mem_data;
            pc4_r          <= in_pc_plus4;
            dest_r         <= in_dest;
        end
    end

    // Retire counter: the outgoing entry counts whenever it leaves, flushed or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (valid_r && !stall) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .mem_data     (mem_r),
        .size         (mem_size_r),
        .mem_unsigned (mem_unsigned_r),
        .byte_off     (byte_off_r),
        .ext_data     (load_s)
    );

    // Write-back source select; reserved encoding falls back to the ALU result.
    always_comb begin
        mux_s = alu_r;
        case (wb_sel_r)
            WB_ALU:  mux_s = alu_r;
            WB_MEM:  mux_s = load_s;
            WB_LINK: mux_s = pc4_r;
            default: mux_s = alu_r;
        endcase
    end

    assign wb_reg_write = valid_r & reg_write_r & (dest_r != {ADDR_W{1'b0}});
    assign wb_dest      = valid_r ? dest_r : {ADDR_W{1'b0}};
    assign wb_data      = valid_r ? mux_s : {DATA_W{1'b0}};
    assign retire_count = count_r;

`ifdef WB_BYPASS_EN
    assign fwd_a_hit = wb_reg_write & (wb_dest == ex_rs_a);
    assign fwd_b_hit = wb_reg_write & (wb_dest == ex_rs_b);
    assign fwd_data  = wb_data;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Randomised bench for memwb_stage with an entry-level reference model.
module tb_memwb_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, in_reg_write, in_mem_unsigned;
    logic [1:0]  in_wb_sel, in_mem_size, in_byte_off;
    logic [31:0] in_alu_result, in_mem_data, in_pc_plus4;
    logic [4:0]  in_dest;
    logic        in_ready, wb_reg_write, in_ready_w, wb_reg_write_w;
    logic [4:0]  wb_dest, wb_dest_w;
    logic [31:0] wb_data, wb_data_w, retire_count;
    logic [2:0]  retire_count_w;
`ifdef WB_BYPASS_EN
    logic [4:0]  ex_rs_a, ex_rs_b;
    logic        fwd_a_hit, fwd_b_hit, fwd_a_hit_w, fwd_b_hit_w;
    logic [31:0] fwd_data, fwd_data_w;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    memwb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_mem_size(in_mem_size),
        .in_mem_unsigned(in_mem_unsigned), .in_byte_off(in_byte_off),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_pc_plus4(in_pc_plus4), .in_dest(in_dest),
`ifdef WB_BYPASS_EN
        .ex_rs_a(ex_rs_a), .ex_rs_b(ex_rs_b), .fwd_a_hit(fwd_a_hit),
        .fwd_b_hit(fwd_b_hit), .fwd_data(fwd_data),
`endif
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
        .retire_count(retire_count)
    );

    // Narrow-counter instance so that wrap-around is reachable quickly.
    memwb_stage #(.CNT_W(3)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .stall(stall), .flush(flush), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_mem_size(in_mem_size),
        .in_mem_unsigned(in_mem_unsigned), .in_byte_off(in_byte_off),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_pc_plus4(in_pc_plus4), .in_dest(in_dest),
`ifdef WB_BYPASS_EN
        .ex_rs_a(ex_rs_a), .ex_rs_b(ex_rs_b), .fwd_a_hit(fwd_a_hit_w),
        .fwd_b_hit(fwd_b_hit_w), .fwd_data(fwd_data_w),
`endif
        .wb_reg_write(wb_reg_write_w), .wb_dest(wb_dest_w), .wb_data(wb_data_w),
        .retire_count(retire_count_w)
    );

    // Reference model: the entry currently held in the stage, plus a retire tally.
    bit          m_valid = 1'b0, m_rw = 1'b0, m_uns = 1'b0;
    int unsigned m_sel = 0, m_size = 0, m_off = 0, m_dest = 0;
    logic [31:0] m_alu = 32'd0, m_mem = 32'd0, m_pc4 = 32'd0;
    longint unsigned m_retired = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0; m_rw = 1'b0; m_uns = 1'b0;
            m_sel = 0; m_size = 0; m_off = 0; m_dest = 0;
            m_alu = 32'd0; m_mem = 32'd0; m_pc4 = 32'd0;
            m_retired = 0;
        end else begin
            if (m_valid && !stall) m_retired = m_retired + 1;
            if (flush) m_valid = 1'b0;
            else if (!stall) begin
                m_valid = in_valid; m_rw = in_reg_write; m_uns = in_mem_unsigned;
                m_sel = in_wb_sel; m_size = in_mem_size; m_off = in_byte_off;
                m_dest = in_dest; m_alu = in_alu_result; m_mem = in_mem_data;
                m_pc4 = in_pc_plus4;
            end
        end
    end

    function automatic logic [31:0] model_load();
        logic [31:0] v;
        if (m_size == 0) begin
            v = (m_mem >> (m_off * 8)) & 32'hFF;
            if (!m_uns && v >= 32'd128) v = v - 32'd256;
        end else if (m_size == 1) begin
            v = (m_mem >> ((m_off / 2) * 16)) & 32'hFFFF;
            if (!m_uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = m_mem;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_data();
        if (!m_valid) return 32'd0;
        if (m_sel == 1) return model_load();
        if (m_sel == 2) return m_pc4;
        return m_alu;
    endfunction

    function automatic logic model_we();
        return m_valid && m_rw && (m_dest != 0);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, model_we()});
            cmp("wb_dest", {27'd0, wb_dest}, m_valid ? m_dest : 32'd0);
            cmp("wb_data", wb_data, model_data());
            cmp("retire_count", retire_count, m_retired[31:0]);
            cmp("retire_count_w", {29'd0, retire_count_w}, {29'd0, m_retired[2:0]});
            cmp("wb_data_w", wb_data_w, model_data());
            cmp("in_ready", {31'd0, in_ready}, {31'd0, ~stall});
`ifdef WB_BYPASS_EN
            cmp("fwd_a_hit", {31'd0, fwd_a_hit}, {31'd0, model_we() && (m_dest == ex_rs_a)});
            cmp("fwd_b_hit", {31'd0, fwd_b_hit}, {31'd0, model_we() && (m_dest == ex_rs_b)});
            cmp("fwd_data", fwd_data, model_data());
`endif
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [1:0] sz, input logic uns, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [4:0] dest);
        in_valid = v; in_reg_write = rw; in_wb_sel = sel; in_mem_size = sz;
        in_mem_unsigned = uns; in_byte_off = off; in_alu_result = alu;
        in_mem_data = mem; in_pc_plus4 = pc4; in_dest = dest;
    endtask

    initial begin
        logic [31:0] cnt_hold;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
`ifdef WB_BYPASS_EN
        ex_rs_a = 5'd0; ex_rs_b = 5'd0;
`endif
        put(1'b1, 1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd7);
        cycle();
        chk_en = 1'b1;
        cycle();
        cmp("rst_we", {31'd0, wb_reg_write}, 32'd0);
        cmp("rst_data", wb_data, 32'd0);
        cmp("rst_cnt", retire_count, 32'd0);

        rst = 1'b0;
        put(1'b1, 1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 5'd5);
        cycle();
        cmp("alu_we", {31'd0, wb_reg_write}, 32'd1);
        cmp("alu_dest", {27'd0, wb_dest}, 32'd5);
        cmp("alu_data", wb_data, 32'h0000_1234);
`ifdef WB_BYPASS_EN
        ex_rs_a = 5'd5; ex_rs_b = 5'd6; #1;
        cmp("byp_a", {31'd0, fwd_a_hit}, 32'd1);
        cmp("byp_b", {31'd0, fwd_b_hit}, 32'd0);
`endif
        put(1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 2'd1, 32'd0, 32'h80FF_7F01, 32'd0, 5'd6);
        cycle();
        cmp("ld_b1s", wb_data, 32'h0000_007F);
        cmp("alu_cnt", retire_count, 32'd1);
        put(1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 2'd3, 32'd0, 32'h80FF_7F01, 32'd0, 5'd6);
        cycle();
        cmp("ld_b3s", wb_data, 32'hFFFF_FF80);
        put(1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 2'd2, 32'd0, 32'h80FF_7F01, 32'd0, 5'd6);
        cycle();
        cmp("ld_h2u", wb_data, 32'h0000_80FF);
        put(1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 2'd3, 32'd0, 32'h80FF_7F01, 32'd0, 5'd6);
        cycle();
        cmp("ld_h3s", wb_data, 32'hFFFF_80FF);
        put(1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 2'd1, 32'd0, 32'h80FF_7F01, 32'd0, 5'd6);
        cycle();
        cmp("ld_w", wb_data, 32'h80FF_7F01);

        put(1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 2'd0, 32'd0, 32'd0, 32'h0000_0040, 5'd0);
        cycle();
        cmp("r0_we", {31'd0, wb_reg_write}, 32'd0);
        cnt_hold = retire_count;
        put(1'b1, 1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 32'h0000_00AA, 32'd0, 32'd0, 5'd3);
        cycle();
        cmp("r0_cnt", retire_count, cnt_hold + 32'd1);
        cmp("a_dest", {27'd0, wb_dest}, 32'd3);

        stall = 1'b1;
        put(1'b1, 1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 32'h0000_0BAD, 32'd0, 32'd0, 5'd9);
        cnt_hold = retire_count;
        for (int i = 0; i < 3; i++) begin
            cycle();
            cmp("stall_dest", {27'd0, wb_dest}, 32'd3);
            cmp("stall_data", wb_data, 32'h0000_00AA);
            cmp("stall_rdy", {31'd0, in_ready}, 32'd0);
            cmp("stall_cnt", retire_count, cnt_hold);
        end
        flush = 1'b1;
        cycle();
        cmp("flush_we", {31'd0, wb_reg_write}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Wrap of the 3-bit counter: eight retirements return it to zero.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        put(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 32'd1, 32'd0, 32'd0, 5'd1);
        cycle();
        for (int i = 0; i < 8; i++) cycle();
        cmp("wrap_big", retire_count, 32'd8);
        cmp("wrap_small", {29'd0, retire_count_w}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 25);
            flush = ($urandom_range(0, 99) < 10);
            put($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                $urandom, $urandom, $urandom, 5'($urandom_range(0, 7)));
`ifdef WB_BYPASS_EN
            ex_rs_a = 5'($urandom_range(0, 7));
            ex_rs_b = 5'($urandom_range(0, 7));
`endif
            cycle();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
